// File: rtl/cdc_handshake_tx.sv
// Sending end of a 4-phase req/ack clock-domain crossing: accepts a word on
// valid/ready, holds it on dataOut with reqOut high until the ack cycle completes.
module cdc_handshake_tx #(
    parameter int LEN    = 32,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [LEN-1:0] dataIn,
    input  logic           validIn,
    output logic           readyOut,
    output logic [LEN-1:0] dataOut,
    output logic           reqOut,
    input  logic           ackIn,
    output logic           doneOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN-1:0]    data_q, data_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic [STAGES-1:0] ack_sync_q, ack_sync_d;
    logic              ack_sync;
    logic              accept;

    // ackIn is asynchronous: only the last flop of the chain is ever observed.
    assign ack_sync   = ack_sync_q[STAGES-1];
    assign ack_sync_d = {ack_sync_q[STAGES-2:0], ackIn};

    // A stale ack from the previous transfer must clear before a new request starts.
    assign readyOut = (state_q == IDLE) && !ack_sync;
    assign accept   = validIn && readyOut;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = dataIn;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            req_q      <= req_d;
            done_q     <= done_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    // reqOut comes straight from a flop so the destination never sees a glitch.
    assign reqOut  = req_q;
    assign dataOut = data_q;
    assign doneOut = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: a transaction-level model is compared
// against the DUT every cycle, plus literal expectations at key cycles.
module tb_cdc_handshake_tx;

    localparam int LEN    = 32;
    localparam int STAGES = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [LEN-1:0] dataIn;
    logic           validIn;
    logic           readyOut;
    logic [LEN-1:0] dataOut;
    logic           reqOut;
    logic           ackIn;
    logic           doneOut;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    cdc_handshake_tx #(.LEN(LEN), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .dataIn   (dataIn),
        .validIn  (validIn),
        .readyOut (readyOut),
        .dataOut  (dataOut),
        .reqOut   (reqOut),
        .ackIn    (ackIn),
        .doneOut  (doneOut)
    );

    always #5 clk = ~clk;

    // Model: ack history queue (front = ack value visible after synchronizing),
    // plus transfer-level flags: a word is outstanding, and its ack has been seen.
    bit             m_hist[$];
    bit             m_busy;
    bit             m_acked;
    bit             m_done;
    logic [LEN-1:0] m_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hist  = {};
            for (int i = 0; i < STAGES; i++) m_hist.push_back(1'b0);
            m_busy  = 1'b0;
            m_acked = 1'b0;
            m_done  = 1'b0;
            m_data  = '0;
        end else begin
            bit s;
            s = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(ackIn);
            m_done = 1'b0;
            if (!m_busy) begin
                if (validIn && !s) begin
                    m_busy = 1'b1;
                    m_data = dataIn;
                end
            end else if (!m_acked) begin
                if (s) m_acked = 1'b1;
            end else if (!s) begin
                m_busy  = 1'b0;
                m_acked = 1'b0;
                m_done  = 1'b1;
            end
        end
    end

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string nm, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk_b("model_ready", readyOut, !m_busy && !m_hist[0]);
            chk_b("model_req",   reqOut,   m_busy && !m_acked);
            chk_w("model_data",  dataOut,  m_data);
            chk_b("model_done",  doneOut,  m_done);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input logic lvl, input string nm);
        for (int i = 0; i < 20 && reqOut !== lvl; i++) @(negedge clk);
        chk_b(nm, reqOut, lvl);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 20 && doneOut !== 1'b1; i++) @(negedge clk);
        chk_b(nm, doneOut, 1'b1);
    endtask

    initial begin
        reset   = 1'b1;
        ackIn   = 1'b0;
        validIn = 1'b0;
        dataIn  = '0;

        // 1: reset held, then released
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        chk_b("rst_req",   reqOut,   1'b0);
        chk_w("rst_data",  dataOut,  '0);
        chk_b("rst_done",  doneOut,  1'b0);
        chk_b("rst_ready", readyOut, 1'b1);
        reset = 1'b0;
        tick(1);
        chk_b("post_rst_req",   reqOut,   1'b0);
        chk_b("post_rst_ready", readyOut, 1'b1);
        chk_w("post_rst_data",  dataOut,  '0);

        // 2: single transfer, accept at edge 1
        validIn = 1'b1;
        dataIn  = 32'hDEADBEEF;
        tick(1);
        validIn = 1'b0;
        dataIn  = 32'h0;
        chk_b("t2_req_e1",  reqOut,  1'b1);
        chk_w("t2_data_e1", dataOut, 32'hDEADBEEF);
        tick(3);
        ackIn = 1'b1;
        tick(2);
        chk_b("t2_req_e6", reqOut, 1'b1);
        tick(1);
        chk_b("t2_req_e7", reqOut, 1'b0);
        ackIn = 1'b0;
        tick(2);
        chk_b("t2_done_e9", doneOut, 1'b0);
        tick(1);
        chk_b("t2_done_e10",  doneOut,  1'b1);
        chk_b("t2_ready_e10", readyOut, 1'b1);
        tick(1);
        chk_b("t2_done_e11",  doneOut,  1'b0);
        chk_b("t2_ready_e11", readyOut, 1'b1);

        // 3: back-to-back words with validIn held high
        validIn = 1'b1;
        dataIn  = 32'h1;
        tick(1);
        chk_b("t3_req1",  reqOut,  1'b1);
        chk_w("t3_data1", dataOut, 32'h1);
        dataIn = 32'h2;
        ackIn  = 1'b1;
        wait_req(1'b0, "t3_req1_low");
        ackIn = 1'b0;
        wait_done("t3_done1");
        chk_b("t3_ready_in_done", readyOut, 1'b1);
        tick(1);
        chk_b("t3_req2",  reqOut,  1'b1);
        chk_w("t3_data2", dataOut, 32'h2);
        chk_b("t3_done_off", doneOut, 1'b0);
        validIn = 1'b0;
        ackIn   = 1'b1;
        wait_req(1'b0, "t3_req2_low");
        ackIn = 1'b0;
        wait_done("t3_done2");
        tick(1);

        // 4: validIn pulse during REQ is ignored
        validIn = 1'b1;
        dataIn  = 32'h1;
        tick(1);
        validIn = 1'b0;
        tick(1);
        validIn = 1'b1;
        dataIn  = 32'hFFFF;
        tick(1);
        validIn = 1'b0;
        tick(1);
        chk_w("t4_data_kept", dataOut, 32'h1);
        chk_b("t4_req_kept",  reqOut,  1'b1);

        // 5: reset in REQ with ack high
        ackIn = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk_b("t5_req_async",  reqOut,  1'b0);
        chk_w("t5_data_async", dataOut, '0);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk_b("t5_ready_blocked", readyOut, 1'b0);
        chk_b("t5_no_done",       doneOut,  1'b0);
        ackIn = 1'b0;
        tick(1);
        chk_b("t5_ready_e1", readyOut, 1'b0);
        tick(1);
        chk_b("t5_ready_e2", readyOut, 1'b1);
        chk_b("t5_no_done2", doneOut,  1'b0);

        // 6: ack high in IDLE blocks accept
        ackIn = 1'b1;
        tick(3);
        chk_b("t6_ready_low", readyOut, 1'b0);
        validIn = 1'b1;
        dataIn  = 32'hCAFE0006;
        tick(2);
        chk_b("t6_no_req", reqOut, 1'b0);
        ackIn = 1'b0;
        tick(1);
        chk_b("t6_req_e1", reqOut, 1'b0);
        tick(1);
        chk_b("t6_ready_e2", readyOut, 1'b1);
        chk_b("t6_req_e2",   reqOut,   1'b0);
        tick(1);
        chk_b("t6_req_e3",  reqOut,  1'b1);
        chk_w("t6_data_e3", dataOut, 32'hCAFE0006);
        validIn = 1'b0;
        ackIn   = 1'b1;
        wait_req(1'b0, "t6_req_low");
        ackIn = 1'b0;
        wait_done("t6_done");
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
